// File: rtl/memory_receive.sv
// memory_receive: in-order load-return path. Each accepted load leaves its
// byte offset, size and signedness in a small tracking queue. Each memory
// response pops the head entry and turns the returned word into a
// sign- or zero-extended load result, registered for one cycle.
module memory_receive #(
  parameter int CORE           = 0,
  parameter int DATA_WIDTH     = 32,
  parameter int ADDRESS_BITS   = 20,
  parameter int NUM_BYTES      = DATA_WIDTH / 8,
  parameter int LOG2_NUM_BYTES = $clog2(NUM_BYTES),
  parameter int QUEUE_DEPTH    = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      load,
  input  logic [ADDRESS_BITS-1:0]   address,
  input  logic [LOG2_NUM_BYTES-1:0] log2_bytes,
  input  logic                      unsigned_load,
  input  logic                      memory_valid,
  input  logic [DATA_WIDTH-1:0]     memory_data,
  output logic [DATA_WIDTH-1:0]     load_data,
  output logic                      load_valid,
  output logic                      load_error,
  output logic                      stall,
  output logic                      protocol_error
);

  localparam int PTR_W   = $clog2(QUEUE_DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = 2 * LOG2_NUM_BYTES + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(QUEUE_DEPTH);

  // Entry layout: {offset, log2_bytes, unsigned_load}
  logic [ENTRY_W-1:0]        queue_mem [QUEUE_DEPTH];
  logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]          rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]          count_q, count_d;
  logic [DATA_WIDTH-1:0]     load_data_q, load_data_d;
  logic                      load_valid_q, load_valid_d;
  logic                      load_error_q, load_error_d;
  logic                      protocol_error_q, protocol_error_d;

  logic                      push, pop, orphan;
  logic [ENTRY_W-1:0]        head;
  logic [LOG2_NUM_BYTES-1:0] head_offset;
  logic [LOG2_NUM_BYTES-1:0] head_size;
  logic                      head_unsigned;
  logic [15:0]               shifted_low;
  logic [DATA_WIDTH-1:0]     extended;
  logic                      misaligned;
  logic                      unused_bits;

  // stall comes only from the registered count, so load/memory_valid never
  // feed back into it combinationally.
  assign stall  = (count_q == FULL_COUNT);
  assign push   = load & ~stall;
  assign pop    = memory_valid & (count_q != '0);
  assign orphan = memory_valid & (count_q == '0);

  assign head          = queue_mem[rd_ptr_q];
  assign head_offset   = head[ENTRY_W-1 -: LOG2_NUM_BYTES];
  assign head_size     = head[LOG2_NUM_BYTES:1];
  assign head_unsigned = head[0];

  // Only the low 16 bits of the shifted word are ever needed (byte or half).
  assign shifted_low = 16'(memory_data >> {head_offset, 3'b000});

  assign unused_bits = ^{address[ADDRESS_BITS-1:LOG2_NUM_BYTES], 32'(CORE)};

  // Queue pointer and occupancy update; pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    count_d  = count_q;
    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (!push && pop) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // Size-dependent extraction, extension and alignment check of the head entry.
  always_comb begin
    extended   = '0;
    misaligned = 1'b0;
    case (head_size)
      LOG2_NUM_BYTES'(0): begin
        extended = {{(DATA_WIDTH-8){~head_unsigned & shifted_low[7]}}, shifted_low[7:0]};
      end
      LOG2_NUM_BYTES'(1): begin
        extended   = {{(DATA_WIDTH-16){~head_unsigned & shifted_low[15]}}, shifted_low};
        misaligned = head_offset[0];
      end
      LOG2_NUM_BYTES'(2): begin
        extended   = memory_data;
        misaligned = (head_offset != '0);
      end
      default: begin
        extended   = '0;
        misaligned = 1'b1;
      end
    endcase
  end

  // Next values of the registered result; data is forced to 0 when idle or in error.
  always_comb begin
    load_valid_d     = pop;
    load_error_d     = pop & misaligned;
    load_data_d      = (pop && !misaligned) ? extended : '0;
    protocol_error_d = protocol_error_q | orphan;
  end

  // Tracking storage; entries beyond the count are don't-care, so no reset.
  always_ff @(posedge clock) begin
    if (push) begin
      queue_mem[wr_ptr_q] <= {address[LOG2_NUM_BYTES-1:0], log2_bytes, unsigned_load};
    end
  end

  // Control and output registers, cleared immediately by reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      count_q          <= '0;
      load_data_q      <= '0;
      load_valid_q     <= 1'b0;
      load_error_q     <= 1'b0;
      protocol_error_q <= 1'b0;
    end else begin
      wr_ptr_q         <= wr_ptr_d;
      rd_ptr_q         <= rd_ptr_d;
      count_q          <= count_d;
      load_data_q      <= load_data_d;
      load_valid_q     <= load_valid_d;
      load_error_q     <= load_error_d;
      protocol_error_q <= protocol_error_d;
    end
  end

  assign load_data      = load_data_q;
  assign load_valid     = load_valid_q;
  assign load_error     = load_error_q;
  assign protocol_error = protocol_error_q;

endmodule

// File: doc/memory_receive.md
# memory_receive

Load-return path of the memory stage, paired with the issue stage that drives `memory_read`, `memory_address` and `memory_byte_en`. It records the alignment and size of every accepted load in an in-order tracking queue. When memory returns the full aligned word, the block pops the matching entry, extracts the addressed byte, half-word or word, and sign- or zero-extends it. The result is delivered to writeback as a registered, one-cycle-valid load result.

## Interface
- `CORE`, 0, core index (debug only).
- `DATA_WIDTH`, 32, memory word width in bits.
- `ADDRESS_BITS`, 20, load address width.
- `NUM_BYTES`, DATA_WIDTH/8, bytes per word.
- `LOG2_NUM_BYTES`, log2(NUM_BYTES), width of offset and size fields.
- `QUEUE_DEPTH`, 4, maximum outstanding loads; must be a power of two, ≥2.

Ports:
- `clock`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low; 0 clears all state immediately.
- `load`  in  1  load issued to memory this cycle; same cycle as `memory_read`.
- `address`  in  ADDRESS_BITS  load address; only `[LOG2_NUM_BYTES-1:0]` is stored.
- `log2_bytes`  in  LOG2_NUM_BYTES  access size: 0 = byte, 1 = half, 2 = word.
- `unsigned_load`  in  1  1 = zero-extend (LBU/LHU), 0 = sign-extend.
- `memory_valid`  in  1  memory returns read data this cycle.
- `memory_data`  in  DATA_WIDTH  full aligned word returned by memory.
- `load_data`  out  DATA_WIDTH  extracted and extended result.
- `load_valid`  out  1  `load_data` valid; one-cycle pulse per response.
- `load_error`  out  1  qualifies `load_valid`: misaligned or illegal-size load.
- `stall`  out  1  queue full; the issue stage must hold `load`.
- `protocol_error`  out  1  sticky; a response arrived with no outstanding load.

## Operation
- Each queue entry holds {offset = `address[LOG2_NUM_BYTES-1:0]`, `log2_bytes`, `unsigned_load`}. The queue uses read/write pointers plus an occupancy count of width log2(QUEUE_DEPTH)+1.
- Push: `load && !stall`. A `load` asserted while `stall` = 1 is dropped and does not push.
- Pop: `memory_valid` with count ≠ 0. Responses are strictly in order; the head entry describes the response.
- Simultaneous push and pop: count is unchanged and both pointers advance. This is legal at any occupancy below full. When full, the push is blocked by `stall` even if a pop occurs in the same cycle.
- `memory_valid` with count = 0 sets `protocol_error`. It produces no `load_valid`, even if a push happens in the same cycle (memory latency is at least 1).
- Extraction, with shift = offset×8:
  - byte: `memory_data[shift +: 8]`.
  - half: `memory_data[shift +: 16]`; requires offset[0] = 0.
  - word: whole word; requires offset = 0.
- Extension fills the upper bits with the top extracted bit when `unsigned_load` = 0, and with 0 otherwise.
- Misaligned access, or `log2_bytes` > 2: `load_data` = 0 and `load_error` = 1, with `load_valid` still pulsed. The queue pops normally.
- Pointers wrap modulo QUEUE_DEPTH.

## Timing
- `stall` = (count == QUEUE_DEPTH). It is decoded from registered count with no combinational path from `load` or `memory_valid`.
- Response latency is 1 cycle: `memory_valid` at edge N gives `load_valid`, `load_data` and `load_error` registered at edge N+1.
- A load pushed at edge N can be matched by `memory_valid` in cycle N+1 at the earliest.
- Outputs deassert in the cycle after a response unless another response arrives; `load_data` returns to 0 when `load_valid` = 0.
- Reset values: `load_data` = 0, `load_valid` = 0, `load_error` = 0, `stall` = 0, `protocol_error` = 0, count = 0, pointers = 0.
- Reset mid-operation discards all outstanding entries. Any in-flight memory response arriving after reset release sets `protocol_error`; the issuing pipeline flushes with reset.

## Test plan
- Byte loads, `memory_data` = 0x8899AABB:
  - offset 3, signed → `load_data` = 0xFFFFFF88.
  - offset 3, unsigned → 0x00000088.
  - offset 0, signed → 0xFFFFFFBB.
  - All one cycle after `memory_valid`, `load_error` = 0.
- Half-word loads, `memory_data` = 0x80011234:
  - offset 2, signed → 0xFFFF8001.
  - offset 0, unsigned → 0x00001234.
  - Word at offset 0 → 0x80011234.
- Misaligned: half at offset 1, then word at offset 2 → two `load_valid` pulses, each with `load_data` = 0 and `load_error` = 1; the queue drains to empty.
- Full queue: 4 back-to-back loads with no response → `stall` = 1 after the 4th push; a 5th `load` is dropped. One response clears `stall` the next cycle. A simultaneous push and pop at count 3 keeps count at 3.
- Protocol error: `memory_valid` with an empty queue → `protocol_error` = 1 and no `load_valid`; it stays 1 until `reset` = 0.
- Reset: 2 loads outstanding, assert `reset` = 0 asynchronously mid-cycle → all outputs 0 immediately and the queue empty. After release, a new load with a byte response at offset 1, data 0x00007F00 → `load_data` = 0x0000007F.
